// File: rtl/accel_hash_ctrl.sv
// Memory-mapped hash offload controller: fetches a 64-byte block, drives the hash
// core, writes the 256-bit digest as eight words and then a completion status word.
module accel_hash_ctrl #(
    parameter logic [15:0] SRC_REG_ADDR = 16'hFF00,
    parameter logic [15:0] CMD_REG_ADDR = 16'hFF04,
    parameter logic [15:0] STATUS_ADDR  = 16'hFF08,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_wrt_en,
    input  logic [15:0]  cpu_addr,
    input  logic [31:0]  cpu_wrt_data,
    input  logic [511:0] accel_rd_data,
    input  logic         hash_done,
    input  logic [255:0] hash_digest,
    output logic [15:0]  accel_addr,
    output logic         accel_wrt_en,
    output logic [31:0]  accel_wrt_data,
    output logic         hash_start,
    output logic [511:0] hash_block,
    output logic         busy
);

    localparam int unsigned      CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        WAIT,
        WRITE,
        STATUS
    } state_t;

    state_t         state_reg, state_next;
    logic [15:0]    src_reg, src_next;
    logic [15:0]    dst_reg, dst_next;
    logic [511:0]   hash_block_reg, hash_block_next;
    logic [255:0]   digest_reg, digest_next;
    logic [2:0]     word_idx_reg, word_idx_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic           overrun_reg, overrun_next;
    logic           timeout_reg, timeout_next;

    logic           src_hit;
    logic           cmd_hit;
    logic [31:0]    digest_words [8];
    logic           unused_cmd_bits;

    assign src_hit = cpu_wrt_en && (cpu_addr == SRC_REG_ADDR);
    assign cmd_hit = cpu_wrt_en && (cpu_addr == CMD_REG_ADDR);

    // Only the start bit and the low address half of a command word carry meaning.
    assign unused_cmd_bits = ^cpu_wrt_data[30:16];

    // Word 0 is the most significant 32 bits of the digest.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digest_words
            assign digest_words[gi] = digest_reg[255-32*gi -: 32];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            src_reg        <= '0;
            dst_reg        <= '0;
            hash_block_reg <= '0;
            digest_reg     <= '0;
            word_idx_reg   <= '0;
            cnt_reg        <= '0;
            overrun_reg    <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            src_reg        <= src_next;
            dst_reg        <= dst_next;
            hash_block_reg <= hash_block_next;
            digest_reg     <= digest_next;
            word_idx_reg   <= word_idx_next;
            cnt_reg        <= cnt_next;
            overrun_reg    <= overrun_next;
            timeout_reg    <= timeout_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        src_next        = src_reg;
        dst_next        = dst_reg;
        hash_block_next = hash_block_reg;
        digest_next     = digest_reg;
        word_idx_next   = word_idx_reg;
        cnt_next        = cnt_reg;
        overrun_next    = overrun_reg;
        timeout_next    = timeout_reg;
        accel_addr      = '0;
        accel_wrt_en    = 1'b0;
        accel_wrt_data  = '0;
        hash_start      = 1'b0;

        // Register stores that arrive mid-operation are dropped but remembered.
        if ((state_reg != IDLE) && (src_hit || cmd_hit)) begin
            overrun_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (src_hit) begin
                    src_next = cpu_wrt_data[15:0];
                end
                if (cmd_hit) begin
                    dst_next = cpu_wrt_data[15:0];
                    if (cpu_wrt_data[31]) begin
                        overrun_next = 1'b0;
                        timeout_next = 1'b0;
                        state_next   = FETCH;
                    end
                end
            end

            FETCH: begin
                accel_addr = src_reg;
                state_next = LATCH;
            end

            LATCH: begin
                accel_addr      = src_reg;
                hash_block_next = accel_rd_data;
                state_next      = START;
            end

            START: begin
                hash_start = 1'b1;
                cnt_next   = '0;
                state_next = WAIT;
            end

            WAIT: begin
                // A completion on the final allowed cycle still counts as success.
                if (hash_done) begin
                    digest_next   = hash_digest;
                    word_idx_next = '0;
                    state_next    = WRITE;
                end else if (cnt_reg == CNT_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = STATUS;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            WRITE: begin
                accel_wrt_en   = 1'b1;
                accel_addr     = dst_reg + {11'd0, word_idx_reg, 2'b00};
                accel_wrt_data = digest_words[word_idx_reg];
                word_idx_next  = word_idx_reg + 3'd1;
                if (word_idx_reg == 3'd7) begin
                    state_next = STATUS;
                end
            end

            STATUS: begin
                accel_wrt_en   = 1'b1;
                accel_addr     = STATUS_ADDR;
                accel_wrt_data = {29'd0, overrun_reg, timeout_reg, ~timeout_reg};
                state_next     = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign hash_block = hash_block_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_accel_hash_ctrl.sv
// Scoreboard bench for accel_hash_ctrl: stimulus queues expected memory writes,
// start pulses and spot checks; one negedge monitor pops and compares them.
module tb_accel_hash_ctrl;

    localparam logic [15:0] SRC_A  = 16'hFF00;
    localparam logic [15:0] CMD_A  = 16'hFF04;
    localparam logic [15:0] STAT_A = 16'hFF08;
    localparam int          TO     = 16;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } wr_t;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [511:0] blk;
    } st_t;

    typedef struct packed {
        logic [127:0] name;
        logic [511:0] act;
        logic [511:0] exp;
    } chk_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_wrt_en;
    logic [15:0]  cpu_addr;
    logic [31:0]  cpu_wrt_data;
    logic [511:0] accel_rd_data;
    logic         hash_done;
    logic [255:0] hash_digest;
    logic [15:0]  accel_addr;
    logic         accel_wrt_en;
    logic [31:0]  accel_wrt_data;
    logic         hash_start;
    logic [511:0] hash_block;
    logic         busy;

    logic [15:0]  cur_src;
    logic [511:0] cur_blk;
    logic [31:0]  wds [8];

    wr_t  exp_q [$];
    st_t  start_q [$];
    chk_t chk_q [$];
    wr_t  we;
    st_t  se;
    chk_t ce;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory model: only the programmed source address returns the block.
    assign accel_rd_data = (accel_addr == cur_src) ? cur_blk : '0;

    accel_hash_ctrl #(
        .SRC_REG_ADDR (SRC_A),
        .CMD_REG_ADDR (CMD_A),
        .STATUS_ADDR  (STAT_A),
        .TIMEOUT      (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_wrt_en     (cpu_wrt_en),
        .cpu_addr       (cpu_addr),
        .cpu_wrt_data   (cpu_wrt_data),
        .accel_rd_data  (accel_rd_data),
        .hash_done      (hash_done),
        .hash_digest    (hash_digest),
        .accel_addr     (accel_addr),
        .accel_wrt_en   (accel_wrt_en),
        .accel_wrt_data (accel_wrt_data),
        .hash_start     (hash_start),
        .hash_block     (hash_block),
        .busy           (busy)
    );

    // Monitor: the only process that compares and counts.
    always @(negedge clk) begin
        if (accel_wrt_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write addr=%h data=%h cyc=%0d, no write expected", accel_addr, accel_wrt_data, cyc);
            end else begin
                we = exp_q.pop_front();
                if (accel_addr !== we.addr || accel_wrt_data !== we.data || 32'(cyc) !== we.cyc) begin
                    n_bad++;
                    $display("FAIL mem_write got addr=%h data=%h cyc=%0d, want addr=%h data=%h cyc=%0d",
                             accel_addr, accel_wrt_data, cyc, we.addr, we.data, we.cyc);
                end else begin
                    $display("write addr=%h data=%h cyc=%0d ok", accel_addr, accel_wrt_data, cyc);
                end
            end
        end
        if (hash_start) begin
            n_cmp++;
            if (start_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_start cyc=%0d, no start expected", cyc);
            end else begin
                se = start_q.pop_front();
                if (32'(cyc) !== se.cyc || hash_block !== se.blk) begin
                    n_bad++;
                    $display("FAIL hash_start got cyc=%0d blk=%h, want cyc=%0d blk=%h", cyc, hash_block, se.cyc, se.blk);
                end else begin
                    $display("start cyc=%0d ok", cyc);
                end
            end
        end
        while (chk_q.size() > 0) begin
            ce = chk_q.pop_front();
            n_cmp++;
            if (ce.act !== ce.exp) begin
                n_bad++;
                $display("FAIL %0s got %h want %h", ce.name, ce.act, ce.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [127:0] nm, input logic [511:0] act, input logic [511:0] exp);
        chk_t c;
        c.name = nm;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic cpu_store(input logic [15:0] a, input logic [31:0] d);
        cpu_wrt_en   = 1'b1;
        cpu_addr     = a;
        cpu_wrt_data = d;
        step();
        cpu_wrt_en   = 1'b0;
        cpu_addr     = '0;
        cpu_wrt_data = '0;
    endtask

    task automatic set_words(input logic [31:0] base, input logic [31:0] stp);
        for (int i = 0; i < 8; i++) wds[i] = base + stp * i;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp_q.size() > 0 || start_q.size() > 0); i++) step();
        chk("drain_writes", exp_q.size(), 0);
        chk("drain_starts", start_q.size(), 0);
        step();
        step();
        chk("end_busy", busy, 0);
        step();
    endtask

    // n=0: no completion. rst_word>=0: reset while that result word is on the bus.
    task automatic run_op(input logic [15:0] src, input logic [15:0] dst, input logic [511:0] blk,
                          input int n, input logic exp_ovr, input bit poke_wait,
                          input bit poke_status, input int rst_word);
        int s;
        int w0;
        bit found;
        logic [255:0] dig;
        wr_t e;
        st_t st;
        cur_src = src;
        cur_blk = blk;
        cpu_store(SRC_A, {16'h0, src});
        st.cyc = 32'(cyc + 3);
        st.blk = blk;
        start_q.push_back(st);
        cpu_store(CMD_A, {16'h8000, dst});
        found = 1'b0;
        s = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (hash_start) begin
                found = 1'b1;
                s = cyc;
            end else begin
                step();
            end
        end
        chk("start_seen", found, 1);
        chk("busy_in_op", busy, 1);
        if (n == 0) begin
            e.addr = STAT_A;
            e.data = {29'd0, exp_ovr, 2'b10};
            e.cyc  = 32'(s + 1 + TO);
            exp_q.push_back(e);
        end else begin
            if (poke_wait) begin
                while (cyc < s + 2) step();
                cpu_store(CMD_A, 32'h8000_0900);
                cpu_store(SRC_A, 32'h0000_0900);
            end
            while (cyc < s + n) step();
            w0 = s + n + 1;
            dig = '0;
            for (int i = 0; i < 8; i++) begin
                dig = {dig[223:0], wds[i]};
                if (rst_word < 0 || i < rst_word) begin
                    e.addr = dst + 16'(4 * i);
                    e.data = wds[i];
                    e.cyc  = 32'(w0 + i);
                    exp_q.push_back(e);
                end
            end
            if (rst_word < 0) begin
                e.addr = STAT_A;
                e.data = {29'd0, exp_ovr, 2'b01};
                e.cyc  = 32'(w0 + 8);
                exp_q.push_back(e);
            end
            hash_done   = 1'b1;
            hash_digest = dig;
            step();
            hash_done   = 1'b0;
            hash_digest = '0;
            if (rst_word >= 0) begin
                while (cyc < w0 + rst_word) step();
                rst = 1'b1;
                #1;
                chk("rstw_wen", accel_wrt_en, 0);
                chk("rstw_busy", busy, 0);
                chk("rstw_block", hash_block, 0);
                step();
                chk("rstw_wen_hold", accel_wrt_en, 0);
                rst = 1'b0;
                step();
                chk("rstw_busy_after", busy, 0);
            end
            if (poke_status) begin
                while (cyc < w0 + 8) step();
                cpu_store(CMD_A, 32'h8000_0A00);
            end
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        cpu_wrt_en   = 1'b0;
        cpu_addr     = '0;
        cpu_wrt_data = '0;
        hash_done    = 1'b0;
        hash_digest  = '0;
        cur_src      = 16'hFFFF;
        cur_blk      = '0;
        set_words(32'h0, 32'h0);
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_wen", accel_wrt_en, 0);
        chk("rst_addr", accel_addr, 0);
        chk("rst_wdata", accel_wrt_data, 0);
        chk("rst_start", hash_start, 0);
        chk("rst_block", hash_block, 0);
        rst = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // Command without start bit, plus a stray completion in IDLE: nothing happens.
        cpu_store(CMD_A, 32'h0000_0600);
        hash_done   = 1'b1;
        hash_digest = {8{32'hDEAD_BEEF}};
        step();
        hash_done   = 1'b0;
        hash_digest = '0;
        repeat (4) step();
        chk("nostart_busy", busy, 0);

        // Basic operation, done 10 cycles after start.
        set_words(32'h1111_1111, 32'h1111_1111);
        run_op(16'h0100, 16'h0200, {64{8'hA5}}, 10, 1'b0, 1'b0, 1'b0, -1);

        // Timeout: no completion, status 0x2.
        run_op(16'h0300, 16'h0400, {64{8'h3C}}, 0, 1'b0, 1'b0, 1'b0, -1);

        // Destination wraps past 0xFFFF; timeout flag cleared by new command.
        set_words(32'hA000_0001, 32'h0101_0101);
        run_op(16'h0100, 16'hFFF8, {32{16'h1234}}, 3, 1'b0, 1'b0, 1'b0, -1);

        // Stores during WAIT are ignored and flagged as overrun.
        set_words(32'h0F0F_0000, 32'h0000_1111);
        run_op(16'h0800, 16'h1000, {16{32'hCAFE_F00D}}, 8, 1'b1, 1'b1, 1'b0, -1);

        // Completion on the last timeout cycle wins; store during STATUS is ignored.
        set_words(32'h5555_0000, 32'h0000_0F01);
        run_op(16'h2000, 16'h3000, {8{64'h0123_4567_89AB_CDEF}}, TO, 1'b0, 1'b0, 1'b1, -1);

        // Reset while result word 3 is being written.
        set_words(32'h7700_0000, 32'h0011_0000);
        run_op(16'h4000, 16'h5000, {64{8'h5A}}, 2, 1'b0, 1'b0, 1'b0, 3);

        // Normal operation after the mid-write reset.
        set_words(32'h1234_5678, 32'h1000_0001);
        run_op(16'h0500, 16'h0700, {128{4'h9}}, 1, 1'b0, 1'b0, 1'b0, -1);

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
